// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DEFAULT_DIV = 106;
    localparam int UART_DATA_BITS   = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - first-word-fall-through byte FIFO with wrap-bit pointers
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,    // system clock
    input  logic                     reset,  // synchronous, active-high
    input  logic                     push,   // write din (ignored when full)
    input  logic [7:0]               din,    // byte to store
    input  logic                     pop,    // drop head entry (ignored when empty)
    output logic [7:0]               dout,   // head entry, valid while !empty
    output logic                     full,   // DEPTH entries stored
    output logic                     empty,  // no entries stored
    output logic [$clog2(DEPTH):0]   level   // stored entry count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];

    // The extra MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_stim.sv
// rtl/uart_tx_stim.sv - queued 8N1 UART transmitter with programmable bit period
module uart_tx_stim
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16
) (
    input  logic                          clk,         // system clock
    input  logic                          reset,       // synchronous, active-high
    input  logic                          in_valid,    // byte offered
    output logic                          in_ready,    // FIFO can accept this cycle
    input  logic [7:0]                    in_data,     // byte to send
    input  logic                          div_we,      // divisor write strobe
    input  logic [DIV_W-1:0]              div_di,      // new divisor
    output logic [DIV_W-1:0]              div_do,      // current divisor
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,  // queued bytes, not counting the shifter
    output logic                          busy,        // frame in progress
    output logic                          ser_tx       // serial line, idle high
);

    uart_state_t      state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] baud_cnt;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             baud_zero;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign baud_zero = (baud_cnt == '0);
    assign div_do    = div_reg;

    // Pop exactly when the FSM loads the shifter: from IDLE, or at the end of
    // STOP so queued frames run back to back.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_STOP: pop = baud_zero && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (in_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= DIV_W'(DEFAULT_DIV);
        end else if (div_we) begin
            div_reg <= (div_di < DIV_W'(2)) ? DIV_W'(2) : div_di;
        end
    end

    // ser_tx is registered from the current state, so the line trails the
    // state register by one clock; every bit still lasts div_lat clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            ser_tx   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            div_lat  <= DIV_W'(DEFAULT_DIV);
        end else begin
            case (state)
                ST_IDLE: begin
                    ser_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shreg    <= fifo_dout;
                        div_lat  <= div_reg;
                        baud_cnt <= div_reg - 1'b1;
                        state    <= ST_START;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    ser_tx <= 1'b0;
                    if (baud_zero) begin
                        baud_cnt <= div_lat - 1'b1;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    ser_tx <= shreg[0];
                    if (baud_zero) begin
                        baud_cnt <= div_lat - 1'b1;
                        shreg    <= shreg >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    ser_tx <= 1'b1;
                    if (baud_zero) begin
                        if (!fifo_empty) begin
                            shreg    <= fifo_dout;
                            div_lat  <= div_reg;
                            baud_cnt <= div_reg - 1'b1;
                            state    <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    ser_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule
